// File: rtl/noc_inject_arbiter_if.sv
// Source-side and router-side handshake bundle for the NoC injection arbiter.
// slave = arbiter side, master = sources/router model side.
interface noc_inject_arbiter_if #(
  parameter int N_SRC  = 4,
  parameter int FLIT_W = 32
) ();
  localparam int GW = $clog2(N_SRC);

  logic [N_SRC-1:0]             src_put;
  logic [N_SRC-1:0][FLIT_W-1:0] src_flit;  // source i at bits [i*FLIT_W +: FLIT_W]
  logic [N_SRC-1:0]             src_ack;
  logic                         noc_ready;
  logic                         noc_en_put;
  logic [FLIT_W-1:0]            noc_put_flit;
  logic                         busy;
  logic [GW-1:0]                grant_id;
  logic                         err_timeout;

  modport master (
    output src_put, src_flit, noc_ready,
    input  src_ack, noc_en_put, noc_put_flit, busy, grant_id, err_timeout
  );

  modport slave (
    input  src_put, src_flit, noc_ready,
    output src_ack, noc_en_put, noc_put_flit, busy, grant_id, err_timeout
  );
endinterface

// File: rtl/noc_inject_arbiter.sv
// Packet-atomic round-robin arbiter sharing one NoC injection port between N_SRC sources.
// Optional stall watchdog enabled by defining NOC_INJECT_ARB_WATCHDOG_EN.
module noc_inject_arbiter #(
  parameter int N_SRC         = 4,
  parameter int FLIT_W        = 32,
  parameter int FLITS_PER_PKT = 4,
  parameter int TIMEOUT       = 64
) (
  input  logic                 clk,
  input  logic                 res_n,
  noc_inject_arbiter_if.slave  bus
);
  localparam int GW = $clog2(N_SRC);
  localparam int CW = (FLITS_PER_PKT > 1) ? $clog2(FLITS_PER_PKT) : 1;

  if (N_SRC < 2 || N_SRC > 8 || FLITS_PER_PKT < 1 || TIMEOUT < 1) begin : g_param_chk
    $error("noc_inject_arbiter: illegal parameter set");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] rr_ptr, rr_nxt;
  logic [GW-1:0] grant_id, grant_nxt;
  logic [CW-1:0] flit_cnt, cnt_nxt;
  logic [GW-1:0] sel;
  logic          sel_vld;
  logic          acc, last, wd_fire;
  int            idx;

  function automatic logic [GW-1:0] nxt_src(input logic [GW-1:0] s);
    return (int'(s) == N_SRC - 1) ? '0 : s + 1'b1;
  endfunction

  // Scan from the far end back toward rr_ptr so the nearest requester wins.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    idx     = 0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (bus.src_put[idx]) begin
        sel     = GW'(idx);
        sel_vld = 1'b1;
      end
    end
  end

  assign acc  = (state == BUSY) && bus.src_put[grant_id] && bus.noc_ready;
  assign last = (flit_cnt == CW'(FLITS_PER_PKT - 1));

  for (genvar i = 0; i < N_SRC; i++) begin : g_ack
    assign bus.src_ack[i] = acc && (grant_id == GW'(i));
  end

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    grant_nxt = grant_id;
    cnt_nxt   = flit_cnt;
    case (state)
      IDLE: if (sel_vld) begin
        grant_nxt = sel;
        cnt_nxt   = '0;
        state_nxt = BUSY;
      end
      BUSY: begin
        if (acc) begin
          if (last) begin
            cnt_nxt   = '0;
            rr_nxt    = nxt_src(grant_id);
            state_nxt = IDLE;
          end else begin
            cnt_nxt = flit_cnt + 1'b1;
          end
        end else if (wd_fire) begin
          cnt_nxt   = '0;
          rr_nxt    = nxt_src(grant_id);
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      flit_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_nxt;
      grant_id <= grant_nxt;
      flit_cnt <= cnt_nxt;
    end
  end

  // Output stage: acceptance already implies router space, so no further gating.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      bus.noc_en_put   <= 1'b0;
      bus.noc_put_flit <= '0;
    end else begin
      bus.noc_en_put <= acc;
      if (acc) bus.noc_put_flit <= bus.src_flit[grant_id];
    end
  end

  assign bus.busy     = (state == BUSY);
  assign bus.grant_id = grant_id;

`ifdef NOC_INJECT_ARB_WATCHDOG_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] stall_cnt;
  logic          err_q;

  // Only a missing src_put counts; router back-pressure holds the count.
  assign wd_fire = (state == BUSY) && !bus.src_put[grant_id] &&
                   (stall_cnt == SW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      stall_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state == IDLE || acc || wd_fire) stall_cnt <= '0;
      else if (!bus.src_put[grant_id])     stall_cnt <= stall_cnt + 1'b1;
      if (wd_fire) err_q <= 1'b1;
    end
  end

  assign bus.err_timeout = err_q;
`else
  assign wd_fire         = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif
endmodule
